// File: rtl/core_pkg.sv
// Shared spike-packet geometry and small helpers for the neuromorphic core.
package core_pkg;

    localparam int NUM_AXONS      = 256;
    localparam int NUM_TICKS      = 16;
    localparam int AXON_W         = $clog2(NUM_AXONS);
    localparam int TICK_W         = $clog2(NUM_TICKS);
    localparam int SPIKE_PKT_W    = AXON_W + TICK_W;
    localparam int AXON_FIELD_MSB = SPIKE_PKT_W - 1;
    localparam int AXON_FIELD_LSB = TICK_W;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/spike_fifo_mem.sv
// Spike FIFO storage: register array, one write port, one async read port.
module spike_fifo_mem
    import core_pkg::*;
#(
    parameter int WIDTH = SPIKE_PKT_W,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ptr_w(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [ptr_w(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]        rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axon_spike_fifo.sv
// Router-to-Controller spike FIFO: standard or fall-through read, occupancy,
// almost_full back-pressure and sticky overflow/underflow flags.
module axon_spike_fifo
    import core_pkg::*;
#(
    parameter int WIDTH     = SPIKE_PKT_W,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      dout,
    output logic                  valid,
    output logic                  wr_ack,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ptr_w(DEPTH):0] count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("axon_spike_fifo: DEPTH must be a power of two >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("axon_spike_fifo: AF_THRESH must be in 1..DEPTH");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             readable;
    logic             pop_acc;
    logic             wr_acc;

    assign readable    = (count != '0);
    assign pop_acc     = rd_en && readable;
    assign wr_acc      = wr_en && (!full || pop_acc);
    assign full        = (count == CW'(DEPTH));
    assign almost_full = (count >= CW'(AF_THRESH));
    assign empty       = !readable;

    // Fall-through exposes the head directly; standard mode shows the popped word.
    assign dout  = (FWFT != 0) ? rdata : dout_q;
    assign valid = (FWFT != 0) ? readable : valid_q;

    spike_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc && rst),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            wr_ack  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wr_ack  <= wr_acc;
            valid_q <= pop_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
                dout_q <= rdata;
            end
            count <= count + CW'(wr_acc) - CW'(pop_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full && !pop_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && !readable) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axon_spike_fifo.sv
// Checks standard and fall-through FIFO instances side by side against a
// queue-based reference model of the spike FIFO.
module tb_axon_spike_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] din = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_err = 1'b0;

    logic [11:0] dout0, dout1;
    logic        valid0, valid1, ack0, ack1, empty0, empty1;
    logic        full0, full1, af0, af1, ovf0, ovf1, unf0, unf1;
    logic [4:0]  count0, count1;

    int checks = 0;
    int fails  = 0;

    logic [11:0] q[$];
    logic        m_ack, m_ovf, m_unf, m_sv;
    logic [11:0] m_sd;

    always #5 clk = ~clk;

    axon_spike_fifo #(
        .WIDTH(12), .DEPTH(16), .FWFT(0), .AF_THRESH(12)
    ) dut_std (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .clr_err(clr_err), .dout(dout0), .valid(valid0), .wr_ack(ack0),
        .empty(empty0), .full(full0), .almost_full(af0), .count(count0),
        .overflow(ovf0), .underflow(unf0)
    );

    axon_spike_fifo #(
        .WIDTH(12), .DEPTH(16), .FWFT(1), .AF_THRESH(12)
    ) dut_fwft (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .clr_err(clr_err), .dout(dout1), .valid(valid1), .wr_ack(ack1),
        .empty(empty1), .full(full1), .almost_full(af1), .count(count1),
        .overflow(ovf1), .underflow(unf1)
    );

    wire [10:0] st0 = {count0, full0, af0, empty0, ovf0, unf0, ack0};
    wire [10:0] st1 = {count1, full1, af1, empty1, ovf1, unf1, ack1};
    wire [47:0] obs = {st0, st1, valid0, dout0, valid1,
                       (valid1 ? dout1 : 12'h000)};

    function automatic logic [47:0] exp_all();
        int          n;
        logic [10:0] st;
        logic [11:0] h;
        n  = q.size();
        st = {5'(n), n == 16, n >= 12, n == 0, m_ovf, m_unf, m_ack};
        h  = (n != 0) ? q[0] : 12'h000;
        return {st, st, m_sv, m_sd, n != 0, h};
    endfunction

    task automatic step(input logic w, input logic [11:0] d,
                        input logic r, input logic c, input logic rs);
        logic pop, was_full, was_empty, wacc;
        logic [11:0] head;
        wr_en = w; din = d; rd_en = r; clr_err = c; rst = rs;
        if (!rs) begin
            q.delete();
            m_ack = 0; m_ovf = 0; m_unf = 0; m_sv = 0; m_sd = '0;
        end else begin
            was_full  = (q.size() == 16);
            was_empty = (q.size() == 0);
            pop  = r && !was_empty;
            wacc = w && (!was_full || pop);
            head = was_empty ? 12'h000 : q[0];
            if (pop) void'(q.pop_front());
            if (wacc) q.push_back(d);
            m_sv  = pop;
            if (pop) m_sd = head;
            m_ack = wacc;
            if (c) begin
                m_ovf = 0; m_unf = 0;
            end else begin
                if (w && was_full && !pop) m_ovf = 1;
                if (r && was_empty) m_unf = 1;
            end
        end
        @(posedge clk);
        #1;
        wr_en = 0; rd_en = 0; clr_err = 0; rst = 1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0);
        step(1, 12'hFFF, 1, 0, 0);
        checks++;
        if (obs !== exp_all()) begin
            fails++;
            $display("FAIL reset got %h want %h", obs, exp_all());
        end
        checks++;
        if ({count0, empty0, valid0, dout0} !== {5'd0, 1'b1, 1'b0, 12'h000}) begin
            fails++;
            $display("FAIL reset_const got %h", {count0, empty0, valid0, dout0});
        end
    endtask

    task automatic test_basic();
        logic [11:0] v[3];
        v[0] = 12'h101; v[1] = 12'h202; v[2] = 12'h303;
        for (int i = 0; i < 3; i++) begin
            step(1, v[i], 0, 0, 1);
            checks++;
            if (obs !== exp_all()) begin
                fails++;
                $display("FAIL basic_wr%0d got %h want %h", i, obs, exp_all());
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, i < 3, 0, 1);
            checks++;
            if (obs !== exp_all()) begin
                fails++;
                $display("FAIL basic_rd%0d got %h want %h", i, obs, exp_all());
            end
            if (i < 3) begin
                checks++;
                if ({valid0, dout0} !== {1'b1, v[i]}) begin
                    fails++;
                    $display("FAIL basic_order%0d got %h want %h",
                             i, {valid0, dout0}, {1'b1, v[i]});
                end
            end
        end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < 17; i++) begin
            step(1, (i < 16) ? 12'(i) : 12'hABC, 0, 0, 1);
            checks++;
            if (obs !== exp_all()) begin
                fails++;
                $display("FAIL fill%0d got %h want %h", i, obs, exp_all());
            end
        end
        checks++;
        if ({full0, ovf0, ack0, count0} !== {1'b1, 1'b1, 1'b0, 5'd16}) begin
            fails++;
            $display("FAIL ovf_const got %h", {full0, ovf0, ack0, count0});
        end
        for (int i = 0; i < 17; i++) begin
            step(0, 0, i < 16, 0, 1);
            checks++;
            if (obs !== exp_all()) begin
                fails++;
                $display("FAIL drain%0d got %h want %h", i, obs, exp_all());
            end
        end
        step(0, 0, 0, 1, 1);
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 16; i++) step(1, 12'h300 + 12'(i), 0, 0, 1);
        step(1, 12'h555, 1, 0, 1);
        checks++;
        if (obs !== exp_all()) begin
            fails++;
            $display("FAIL simul got %h want %h", obs, exp_all());
        end
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 1, 0, 1);
            checks++;
            if (obs !== exp_all()) begin
                fails++;
                $display("FAIL simul_drain%0d got %h want %h", i, obs, exp_all());
            end
        end
        checks++;
        if (dout0 !== 12'h555) begin
            fails++;
            $display("FAIL simul_last got %h want 555", dout0);
        end
    endtask

    task automatic test_underflow();
        step(0, 0, 1, 0, 1);
        checks++;
        if (obs !== exp_all()) begin
            fails++;
            $display("FAIL unf got %h want %h", obs, exp_all());
        end
        step(0, 0, 0, 1, 1);
        checks++;
        if (obs !== exp_all()) begin
            fails++;
            $display("FAIL unf_clr got %h want %h", obs, exp_all());
        end
        step(1, 12'h0E1, 1, 0, 1);
        checks++;
        if (obs !== exp_all()) begin
            fails++;
            $display("FAIL empty_wr_rd got %h want %h", obs, exp_all());
        end
        step(0, 0, 1, 1, 1);
        checks++;
        if (obs !== exp_all()) begin
            fails++;
            $display("FAIL empty_wr_rd_pop got %h want %h", obs, exp_all());
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 40; i++) begin
            step(1, 12'(i), 0, 0, 1);
            step(0, 0, 1, 0, 1);
            checks++;
            if (obs !== exp_all()) begin
                fails++;
                $display("FAIL wrap%0d got %h want %h", i, obs, exp_all());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1, 12'h0A0 + 12'(i), 0, 0, 1);
        step(1, 12'h0FF, 1, 0, 0);
        checks++;
        if (obs !== exp_all()) begin
            fails++;
            $display("FAIL rst_mid got %h want %h", obs, exp_all());
        end
        step(1, 12'h077, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        checks++;
        if ({valid0, dout0} !== {1'b1, 12'h077}) begin
            fails++;
            $display("FAIL rst_mid_first got %h want 1077", {valid0, dout0});
        end
    endtask

    task automatic test_random();
        logic w, r, c;
        for (int i = 0; i < 400; i++) begin
            if ((i / 50) % 2 == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            c = ($urandom_range(0, 15) == 0);
            step(w, 12'($urandom), r, c, 1);
            checks++;
            if (obs !== exp_all()) begin
                fails++;
                $display("FAIL rand%0d got %h want %h", i, obs, exp_all());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_overflow();
        test_full_simul();
        test_underflow();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
